// File: rtl/half_adder_gt.sv
// Per-lane gate-level half adder: combinational sum/carry plus an optional
// registered copy with valid tracking for pipelined users.
module half_adder_gt #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             vld,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             vld_q
);

  // One xor/and pair per lane; lanes never interact, so c is never fed into s.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    xor u_xor (s[i], a[i], b[i]);
    and u_and (c[i], a[i], b[i]);
  end

  if (REG_OUT) begin : g_reg
    // vld_q follows vld every edge; data only updates on a qualified edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q   <= '0;
        c_q   <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld;
        if (vld) begin
          s_q <= a ^ b;
          c_q <= a & b;
        end
      end
    end
  end else begin : g_noreg
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, vld};
    assign s_q   = '0;
    assign c_q   = '0;
    assign vld_q = 1'b0;
  end

endmodule

// File: tb/tb_half_adder_gt.sv
// Directed bench for half_adder_gt: comb sweep, full-adder composition,
// registered path, async reset, 4-lane operation and back-to-back captures.
module tb_half_adder_gt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // WIDTH=1 registered instance
  logic a1, b1, v1, s1, c1, s1q, c1q, v1q;
  half_adder_gt #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .vld(v1),
    .s(s1), .c(c1), .s_q(s1q), .c_q(c1q), .vld_q(v1q));

  // WIDTH=4 registered instance
  logic [3:0] a4, b4, s4, c4, s4q, c4q;
  logic       v4, v4q;
  half_adder_gt #(.WIDTH(4), .REG_OUT(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .vld(v4),
    .s(s4), .c(c4), .s_q(s4q), .c_q(c4q), .vld_q(v4q));

  // Full adder: two comb-only instances plus OR
  logic fa_a, fa_b, fa_cin, hs0, hc0, fa_s, hc1, fa_cout;
  logic q0s, q0c, q0v, q1s, q1c, q1v;
  half_adder_gt #(.WIDTH(1), .REG_OUT(1'b0)) ha0 (
    .clk(clk), .rst_n(rst_n), .a(fa_a), .b(fa_b), .vld(1'b1),
    .s(hs0), .c(hc0), .s_q(q0s), .c_q(q0c), .vld_q(q0v));
  half_adder_gt #(.WIDTH(1), .REG_OUT(1'b0)) ha1 (
    .clk(clk), .rst_n(rst_n), .a(hs0), .b(fa_cin), .vld(1'b1),
    .s(fa_s), .c(hc1), .s_q(q1s), .c_q(q1c), .vld_q(q1v));
  assign fa_cout = hc0 | hc1;

  task automatic test_reset();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b000) begin
      errors++; $display("FAIL reset_u1: got %b want 000", {s1q, c1q, v1q});
    end
    checks++;
    if ({s4q, c4q, v4q} !== 9'b0) begin
      errors++; $display("FAIL reset_u4: got %b want 0", {s4q, c4q, v4q});
    end
    checks++;
    if ({s1, c1} !== 2'b01) begin
      errors++; $display("FAIL reset_comb: got %b want 01", {s1, c1});
    end
    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_comb_sweep();
    logic [1:0] want [4];
    want[0] = 2'b00; want[1] = 2'b10; want[2] = 2'b10; want[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #5;
      checks++;
      if ({s1, c1} !== want[i]) begin
        errors++; $display("FAIL comb_sweep ab=%0d: got sc=%b want %b", i, {s1, c1}, want[i]);
      end
    end
  endtask

  task automatic test_full_adder();
    int sum;
    for (int i = 0; i < 8; i++) begin
      fa_a = i[2]; fa_b = i[1]; fa_cin = i[0];
      sum = int'(i[2]) + int'(i[1]) + int'(i[0]);
      #2;
      checks++;
      if ({fa_cout, fa_s} !== sum[1:0]) begin
        errors++; $display("FAIL full_adder abc=%0d: got cout,s=%b want %b", i, {fa_cout, fa_s}, sum[1:0]);
      end
    end
    checks++;
    if ({q0s, q0c, q0v, q1s, q1c, q1v} !== 6'b0) begin
      errors++; $display("FAIL noreg_tied: got %b want 000000", {q0s, q0c, q0v, q1s, q1c, q1v});
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b011) begin
      errors++; $display("FAIL reg_capture: got %b want 011", {s1q, c1q, v1q});
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b010) begin
      errors++; $display("FAIL reg_hold: got %b want 010", {s1q, c1q, v1q});
    end
    @(negedge clk);
    v1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b101) begin
      errors++; $display("FAIL reg_capture2: got %b want 101", {s1q, c1q, v1q});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #2;
    checks++;
    if ({c1q, v1q} !== 2'b11) begin
      errors++; $display("FAIL areset_pre: got c_q,vld_q=%b want 11", {c1q, v1q});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b000) begin
      errors++; $display("FAIL areset_clear: got %b want 000", {s1q, c1q, v1q});
    end
    a1 = 1'b0; b1 = 1'b1;
    #1;
    checks++;
    if ({s1, c1} !== 2'b10) begin
      errors++; $display("FAIL areset_comb: got sc=%b want 10", {s1, c1});
    end
    @(posedge clk); #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b000) begin
      errors++; $display("FAIL areset_held: got %b want 000", {s1q, c1q, v1q});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1q, c1q, v1q} !== 3'b101) begin
      errors++; $display("FAIL areset_first_capture: got %b want 101", {s1q, c1q, v1q});
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic test_width4();
    a4 = 4'b1011; b4 = 4'b0110;
    #1;
    checks++;
    if ({s4, c4} !== {4'b1101, 4'b0010}) begin
      errors++; $display("FAIL width4_comb: got s=%b c=%b want s=1101 c=0010", s4, c4);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [3:0] ws [4];
    logic [3:0] wc [4];
    va[0] = 4'b1011; vb[0] = 4'b0110; ws[0] = 4'b1101; wc[0] = 4'b0010;
    va[1] = 4'b1111; vb[1] = 4'b1111; ws[1] = 4'b0000; wc[1] = 4'b1111;
    va[2] = 4'b1010; vb[2] = 4'b0101; ws[2] = 4'b1111; wc[2] = 4'b0000;
    va[3] = 4'b0000; vb[3] = 4'b1001; ws[3] = 4'b1001; wc[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = va[i]; b4 = vb[i]; v4 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({s4q, c4q, v4q} !== {ws[i], wc[i], 1'b1}) begin
        errors++; $display("FAIL b2b[%0d]: got s_q=%b c_q=%b vld_q=%b want %b %b 1", i, s4q, c4q, v4q, ws[i], wc[i]);
      end
    end
    @(negedge clk);
    v4 = 1'b0; a4 = 4'b1111; b4 = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if ({s4q, c4q, v4q} !== {4'b1001, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL b2b_hold: got s_q=%b c_q=%b vld_q=%b want 1001 0000 0", s4q, c4q, v4q);
    end
  endtask

  initial begin
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a4 = '0; b4 = '0; v4 = 1'b0;
    fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0;
    test_reset();
    test_comb_sweep();
    test_full_adder();
    test_registered();
    test_async_reset();
    test_width4();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
